// File: rtl/mac_psum_acc_sequencer.sv
// Psum stream sequencer between one MAC lane and the psum accumulator: tags beats with
// inter_end/accum_end and counts final accumulator outputs. Optional MAC_ACC_SEQ_PERF_EN adds perf counters.
module mac_psum_acc_sequencer #(
   parameter int MAX_LEN = 64,
   parameter int PASS_W  = 16,
   parameter int LEN_W   = 7
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_cfg_len,
   input  logic [PASS_W-1:0] i_cfg_pass,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_cfg_err,
`ifdef MAC_ACC_SEQ_PERF_EN
   output logic [31:0]       o_perf_stall,
   output logic [31:0]       o_perf_cycles,
`endif
   input  logic              i_psum_valid,
   output logic              o_psum_ready,
   input  logic [31:0]       i_psum_data,
   output logic              o_acc_psum_valid,
   input  logic              i_acc_psum_ready,
   output logic [31:0]       o_acc_psum_data,
   output logic              o_acc_inter_end,
   output logic              o_acc_accum_end,
   input  logic              i_acc_out_valid,
   input  logic              i_acc_out_ready,
   input  logic              i_acc_out_aend
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        r_state;
   logic [LEN_W-1:0]  r_len;
   logic [PASS_W-1:0] r_pass;
   logic [LEN_W-1:0]  r_elem_cnt;
   logic [PASS_W-1:0] r_pass_cnt;
   logic [LEN_W-1:0]  r_out_cnt;
   logic              r_cfg_err;

   logic              w_run;
   logic              w_drain;
   logic              w_cfg_ok;
   logic              w_accept;
   logic              w_beat;
   logic              w_last_elem;
   logic              w_last_pass;
   logic              w_out_hs;
   logic [LEN_W-1:0]  w_out_cnt_nxt;

   assign w_run    = (r_state == S_RUN);
   assign w_drain  = (r_state == S_DRAIN);
   assign w_cfg_ok = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN)) && (i_cfg_pass != '0);
   assign w_accept = (r_state == S_IDLE) && i_start && w_cfg_ok;

   assign o_acc_psum_valid = i_psum_valid & w_run;
   assign o_psum_ready     = i_acc_psum_ready & w_run;
   assign o_acc_psum_data  = i_psum_data;

   assign w_beat      = o_acc_psum_valid & i_acc_psum_ready;
   assign w_last_elem = (r_elem_cnt == r_len - LEN_W'(1));
   assign w_last_pass = (r_pass_cnt == r_pass - PASS_W'(1));

   // The accumulator samples tags without qualification, so they must be low outside beats.
   assign o_acc_inter_end = w_beat & w_last_elem;
   assign o_acc_accum_end = w_beat & w_last_pass;

   assign w_out_hs      = i_acc_out_valid & i_acc_out_ready & i_acc_out_aend & (w_run | w_drain);
   assign w_out_cnt_nxt = r_out_cnt + LEN_W'(w_out_hs);

   assign o_busy    = (r_state != S_IDLE);
   assign o_done    = (r_state == S_DONE);
   assign o_cfg_err = r_cfg_err;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= S_IDLE;
         r_len      <= '0;
         r_pass     <= '0;
         r_elem_cnt <= '0;
         r_pass_cnt <= '0;
         r_out_cnt  <= '0;
         r_cfg_err  <= 1'b0;
      end else begin
         r_cfg_err <= 1'b0;
         if (w_out_hs) begin
            r_out_cnt <= w_out_cnt_nxt;
         end
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (w_cfg_ok) begin
                     r_state    <= S_RUN;
                     r_len      <= i_cfg_len;
                     r_pass     <= i_cfg_pass;
                     r_elem_cnt <= '0;
                     r_pass_cnt <= '0;
                     r_out_cnt  <= '0;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_beat) begin
                  if (w_last_elem) begin
                     r_elem_cnt <= '0;
                     if (w_last_pass) begin
                        r_state <= S_DRAIN;
                     end else begin
                        r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                     end
                  end else begin
                     r_elem_cnt <= r_elem_cnt + LEN_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               // Outputs may all have arrived during RUN, so test the held count as well.
               if ((r_out_cnt == r_len) || (w_out_cnt_nxt == r_len)) begin
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MAC_ACC_SEQ_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_cycles;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_perf_stall  <= '0;
         r_perf_cycles <= '0;
      end else if (w_accept) begin
         r_perf_stall  <= '0;
         r_perf_cycles <= '0;
      end else begin
         if (w_run && i_psum_valid && !i_acc_psum_ready && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         if ((r_state != S_IDLE) && (r_perf_cycles != '1)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
         end
      end
   end

   assign o_perf_stall  = r_perf_stall;
   assign o_perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_mac_psum_acc_sequencer.sv
// Scoreboard bench for mac_psum_acc_sequencer: random tiles, expected beats/tags/done queued by the driver,
// checked by an independent monitor on the falling edge.
module tb_mac_psum_acc_sequencer;
   localparam int LEN_W  = 7;
   localparam int PASS_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_start = 1'b0;
   logic [LEN_W-1:0]  i_cfg_len = '0;
   logic [PASS_W-1:0] i_cfg_pass = '0;
   logic              o_busy, o_done, o_cfg_err;
   logic              i_psum_valid = 1'b0;
   logic              o_psum_ready;
   logic [31:0]       i_psum_data = '0;
   logic              o_acc_psum_valid;
   logic              i_acc_psum_ready = 1'b0;
   logic [31:0]       o_acc_psum_data;
   logic              o_acc_inter_end, o_acc_accum_end;
   logic              i_acc_out_valid = 1'b0;
   logic              i_acc_out_ready = 1'b0;
   logic              i_acc_out_aend = 1'b0;
`ifdef MAC_ACC_SEQ_PERF_EN
   logic [31:0]       o_perf_stall, o_perf_cycles;
`endif

   mac_psum_acc_sequencer #(.MAX_LEN(64), .PASS_W(PASS_W), .LEN_W(LEN_W)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(i_start),
      .i_cfg_len(i_cfg_len), .i_cfg_pass(i_cfg_pass),
      .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err),
`ifdef MAC_ACC_SEQ_PERF_EN
      .o_perf_stall(o_perf_stall), .o_perf_cycles(o_perf_cycles),
`endif
      .i_psum_valid(i_psum_valid), .o_psum_ready(o_psum_ready), .i_psum_data(i_psum_data),
      .o_acc_psum_valid(o_acc_psum_valid), .i_acc_psum_ready(i_acc_psum_ready),
      .o_acc_psum_data(o_acc_psum_data),
      .o_acc_inter_end(o_acc_inter_end), .o_acc_accum_end(o_acc_accum_end),
      .i_acc_out_valid(i_acc_out_valid), .i_acc_out_ready(i_acc_out_ready),
      .i_acc_out_aend(i_acc_out_aend)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] d;
      logic        ie;
      logic        ae;
   } beat_t;

   beat_t       exp_q[$];
   int unsigned done_q[$];
   int unsigned err_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_done_seen = 0;
   logic        m_run = 1'b0;
   beat_t       mon_e;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every presented beat, done and cfg_err pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid_pass", {63'd0, o_acc_psum_valid}, {63'd0, i_psum_valid & m_run});
         chk("ready_pass", {63'd0, o_psum_ready}, {63'd0, i_acc_psum_ready & m_run});
         if (o_acc_psum_valid && i_acc_psum_ready) begin
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", {63'd0, o_acc_psum_valid}, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("beat_data", {32'd0, o_acc_psum_data}, {32'd0, mon_e.d});
               chk("inter_end", {63'd0, o_acc_inter_end}, {63'd0, mon_e.ie});
               chk("accum_end", {63'd0, o_acc_accum_end}, {63'd0, mon_e.ae});
            end
         end else begin
            chk("tags_off_beat", {62'd0, o_acc_inter_end, o_acc_accum_end}, 64'd0);
         end
         if (o_done) begin
            n_done_seen++;
            if (done_q.size() == 0) chk("done_unexpected", {63'd0, o_done}, 64'd0);
            else chk("done_cycle", {32'd0, cyc}, {32'd0, done_q.pop_front()});
         end
         if (o_cfg_err) begin
            if (err_q.size() == 0) chk("cfg_err_unexpected", {63'd0, o_cfg_err}, 64'd0);
            else chk("cfg_err_cycle", {32'd0, cyc}, {32'd0, err_q.pop_front()});
         end
      end
   end

   // rmode: 0 random ready, 1 always ready, 2 ready toggles each cycle, 3 ready low for the first 5 cycles.
   task automatic run_tile(input int L, input int P, input int rmode, input int vpct, input int abort_at);
      int          total;
      int          nb = 0;
      int          no = 0;
      int          fin;
      int          guard = 0;
      int          base_done;
      int unsigned lb = 0;
      int unsigned lo = 0;
      int unsigned exp_done;
      logic        v, r, ov, ordy, oa, bt;
      logic [31:0] dat[$];
      beat_t       b;
      total = L * P;
      for (int k = 0; k < total; k++) begin
         b.d  = $urandom;
         b.ie = ((k % L) == L - 1);
         b.ae = ((k / L) == P - 1);
         dat.push_back(b.d);
         exp_q.push_back(b);
      end
      @(posedge clk); #1;
      i_start = 1'b1;
      i_cfg_len = LEN_W'(L);
      i_cfg_pass = PASS_W'(P);
      @(posedge clk); #1;
      i_start = 1'b0;
      m_run = 1'b1;
      chk("busy_after_start", {63'd0, o_busy}, 64'd1);
      base_done = n_done_seen;
      while ((nb < total || no < L) && guard < 20000) begin
         guard++;
         v = (nb < total) && ($urandom_range(99) < vpct);
         case (rmode)
            0:       r = ($urandom_range(99) < 60);
            1:       r = 1'b1;
            2:       r = cyc[0];
            default: r = (guard > 5);
         endcase
         i_psum_valid = v;
         i_acc_psum_ready = r;
         i_psum_data = (nb < total) ? dat[nb] : $urandom;
         bt = v & r;
         fin = nb + int'(bt) - L * (P - 1);
         ov = 1'($urandom_range(1));
         ordy = 1'($urandom_range(1));
         oa = ($urandom_range(3) != 0) && (no < fin);
         i_acc_out_valid = ov;
         i_acc_out_ready = ordy;
         i_acc_out_aend = oa;
         i_start = ($urandom_range(7) == 0);
         i_cfg_len = LEN_W'($urandom);
         i_cfg_pass = PASS_W'($urandom);
         if (bt) lb = cyc;
         if (ov & ordy & oa) lo = cyc;
         @(posedge clk); #1;
         if (bt) nb++;
         if (ov & ordy & oa) no++;
         if (nb == total) m_run = 1'b0;
         if (abort_at > 0 && nb == abort_at) begin
            i_start = 1'b0;
            i_psum_valid = 1'b1;
            i_acc_psum_ready = 1'b1;
            m_run = 1'b0;
            rst_n = 1'b0;
            #1;
            chk("reset_outputs", {57'd0, o_busy, o_done, o_cfg_err, o_acc_psum_valid, o_psum_ready,
                                  o_acc_inter_end, o_acc_accum_end}, 64'd0);
            exp_q.delete();
            done_q.delete();
            @(posedge clk); #1;
            i_psum_valid = 1'b0;
            i_acc_psum_ready = 1'b0;
            i_acc_out_valid = 1'b0;
            rst_n = 1'b1;
            return;
         end
      end
      i_start = 1'b0;
      i_psum_valid = 1'b0;
      i_acc_out_valid = 1'b0;
      i_acc_out_ready = 1'b0;
      i_acc_out_aend = 1'b0;
      chk("tile_beats", nb, total);
      chk("tile_outputs", no, L);
      exp_done = (lo + 1 > lb + 2) ? lo + 1 : lb + 2;
      done_q.push_back(exp_done);
      for (int i = 0; i < 12 && n_done_seen == base_done; i++) @(posedge clk);
      #1;
      chk("done_seen", n_done_seen - base_done, 1);
      chk("idle_after_done", {63'd0, o_busy}, 64'd0);
   endtask

   task automatic bad_start(input int L, input int P);
      @(posedge clk); #1;
      i_start = 1'b1;
      i_cfg_len = LEN_W'(L);
      i_cfg_pass = PASS_W'(P);
      err_q.push_back(cyc + 1);
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("busy_after_bad_start", {63'd0, o_busy}, 64'd0);
      @(posedge clk); #1;
      chk("cfg_err_single", {63'd0, o_cfg_err}, 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {25'd0, o_acc_psum_data, o_busy, o_done, o_cfg_err, o_acc_psum_valid,
                          o_psum_ready, o_acc_inter_end, o_acc_accum_end}, 64'd0);
      rst_n = 1'b1;
      run_tile(4, 3, 1, 100, 0);
      run_tile(2, 2, 2, 100, 0);
      run_tile(1, 1, 1, 100, 0);
      bad_start(0, 1);
      bad_start(5, 0);
      bad_start(65, 2);
      run_tile(64, 2, 0, 80, 0);
      run_tile(8, 4, 0, 90, 11);
      run_tile(3, 1, 0, 70, 0);
      for (int t = 0; t < 6; t++) begin
         run_tile(int'($urandom_range(16, 1)), int'($urandom_range(4, 1)), 0,
                  int'($urandom_range(100, 50)), 0);
      end
`ifdef MAC_ACC_SEQ_PERF_EN
      run_tile(4, 1, 3, 100, 0);
      chk("perf_stall", {32'd0, o_perf_stall}, 64'd5);
`endif
      repeat (3) @(posedge clk);
      chk("beats_left", exp_q.size(), 0);
      chk("dones_left", done_q.size(), 0);
      chk("errs_left", err_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
